// File: rtl/eth_rx_pkg.sv
// rtl/eth_rx_pkg.sv - shared receive-path state encodings and protocol constants
package eth_rx_pkg;

  // One-hot, shared with the IP receive stage
  typedef enum logic [3:0] {
    ST_IDLE    = 4'd1,
    ST_HEADER  = 4'd2,
    ST_PAYLOAD = 4'd4,
    ST_DONE    = 4'd8
  } rx_state_t;

  localparam int         UDP_HDR_LEN  = 8;
  localparam logic [7:0] IP_PROTO_UDP = 8'h11;

  // Ones-complement doubling: w + w with end-around carry is a 1-bit rotate left
  function automatic logic [15:0] oc_double(input logic [15:0] w);
    return {w[14:0], w[15]};
  endfunction

endpackage

// File: rtl/ones_comp_acc.sv
// rtl/ones_comp_acc.sv - 16-bit ones-complement accumulator (built only with UDP_CHECKSUM_EN)
`ifdef UDP_CHECKSUM_EN
module ones_comp_acc #(
  parameter logic [15:0] SEED = 16'h0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        clear,
  input  logic        add,
  input  logic [15:0] word,
  output logic [15:0] sum
);

  logic [15:0] base;
  logic [15:0] addend;
  logic [16:0] raw;

  // clear restarts from SEED and may add a word in the same cycle
  always_comb begin
    base   = clear ? SEED : sum;
    addend = add ? word : 16'h0000;
    raw    = {1'b0, base} + {1'b0, addend};
  end

  // Fold the carry back in every cycle so sum is always the folded result
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sum <= 16'h0000;
    end else if (clear || add) begin
      sum <= raw[15:0] + {15'd0, raw[16]};
    end
  end

endmodule
`endif

// File: rtl/udp_recv.sv
// rtl/udp_recv.sv - UDP header parser and payload flagger (optional checksum: UDP_CHECKSUM_EN)
import eth_rx_pkg::*;

module udp_recv #(
  parameter int MAX_LEN = 1472
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        rx_enable,
  input  logic [7:0]  data,
  input  logic        is_icmp,
  input  logic [31:0] remote_ip,
  input  logic [31:0] to_ip,
  output logic        active,
  output logic [15:0] remote_port,
  output logic [15:0] to_port,
  output logic [15:0] payload_len,
  output logic [10:0] byte_no,
  output logic        done,
  output logic        checksum_ok
);

  localparam logic [16:0] LEN_MIN   = 17'(UDP_HDR_LEN);
  localparam logic [16:0] LEN_LIMIT = 17'(MAX_LEN + UDP_HDR_LEN);

  rx_state_t   state;
  logic [3:0]  hdr_cnt;
  logic [7:0]  hi_byte;
  logic [15:0] rx_word;
  logic        last_byte;

  // hi_byte holds the previous byte, so this is the 16-bit word ending on the current byte
  assign rx_word   = {hi_byte, data};
  assign last_byte = ({5'd0, byte_no} == payload_len);
  assign active    = rx_enable & (state == ST_PAYLOAD);

  // Packet parser: header field capture, length screening, payload counting
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      hdr_cnt     <= 4'd0;
      hi_byte     <= 8'h00;
      remote_port <= 16'h0000;
      to_port     <= 16'h0000;
      payload_len <= 16'h0000;
      byte_no     <= 11'd0;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;
      if (!rx_enable) begin
        state <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: begin
            if (is_icmp) begin
              state <= ST_DONE;
            end else begin
              remote_port[15:8] <= data;
              hdr_cnt           <= 4'd2;
              state             <= ST_HEADER;
            end
          end
          ST_HEADER: begin
            hdr_cnt <= hdr_cnt + 4'd1;
            case (hdr_cnt)
              4'd2: remote_port[7:0] <= data;
              4'd3: to_port[15:8]    <= data;
              4'd4: to_port[7:0]     <= data;
              4'd5: hi_byte          <= data;
              4'd6: begin
                if ({1'b0, rx_word} < LEN_MIN || {1'b0, rx_word} > LEN_LIMIT) begin
                  state <= ST_DONE;
                end else begin
                  payload_len <= rx_word - 16'(UDP_HDR_LEN);
                end
              end
              4'd7: hi_byte <= data;
              4'd8: begin
                if (payload_len == 16'h0000) begin
                  done  <= 1'b1;
                  state <= ST_DONE;
                end else begin
                  byte_no <= 11'd1;
                  state   <= ST_PAYLOAD;
                end
              end
              default: state <= ST_DONE;
            endcase
          end
          ST_PAYLOAD: begin
            hi_byte <= data;
            if (last_byte) begin
              done  <= 1'b1;
              state <= ST_DONE;
            end else begin
              byte_no <= byte_no + 11'd1;
            end
          end
          ST_DONE: state <= ST_DONE;
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

`ifdef UDP_CHECKSUM_EN
  logic        acc_clear;
  logic        acc_add;
  logic [15:0] acc_word;
  logic [15:0] acc_sum;
  logic        ck_zero;

  // Word schedule: IPs on hdr 1-4, dst port on 5, doubled length (pseudo + header copy) on 6,
  // src port on 7, checksum on 8, then payload words; protocol 0x0011 is the accumulator seed
  always_comb begin
    acc_clear = 1'b0;
    acc_add   = 1'b0;
    acc_word  = 16'h0000;
    if (rx_enable) begin
      case (state)
        ST_IDLE: begin
          if (!is_icmp) begin
            acc_clear = 1'b1;
            acc_add   = 1'b1;
            acc_word  = remote_ip[31:16];
          end
        end
        ST_HEADER: begin
          acc_add = 1'b1;
          case (hdr_cnt)
            4'd2:    acc_word = remote_ip[15:0];
            4'd3:    acc_word = to_ip[31:16];
            4'd4:    acc_word = to_ip[15:0];
            4'd5:    acc_word = to_port;
            4'd6:    acc_word = oc_double(rx_word);
            4'd7:    acc_word = remote_port;
            4'd8:    acc_word = rx_word;
            default: acc_add  = 1'b0;
          endcase
        end
        ST_PAYLOAD: begin
          if (!byte_no[0]) begin
            acc_add  = 1'b1;
            acc_word = rx_word;
          end else if (last_byte) begin
            acc_add  = 1'b1;
            acc_word = {data, 8'h00};
          end
        end
        default: acc_add = 1'b0;
      endcase
    end
  end

  // A zero checksum field means the sender did not compute one
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ck_zero <= 1'b0;
    end else if (rx_enable && state == ST_HEADER && hdr_cnt == 4'd8) begin
      ck_zero <= (rx_word == 16'h0000);
    end
  end

  ones_comp_acc #(.SEED({8'h00, IP_PROTO_UDP})) u_acc (
    .clock (clock),
    .reset (reset),
    .clear (acc_clear),
    .add   (acc_add),
    .word  (acc_word),
    .sum   (acc_sum)
  );

  assign checksum_ok = done & ((acc_sum == 16'hFFFF) | ck_zero);
`else
  logic unused_ip;
  assign unused_ip   = ^{remote_ip, to_ip};
  assign checksum_ok = done;
`endif

endmodule

// File: tb/tb_udp_recv.sv
// tb/tb_udp_recv.sv - directed self-checking bench for udp_recv
module tb_udp_recv;

  logic        clock = 1'b0;
  logic        reset;
  logic        rx_enable;
  logic [7:0]  data;
  logic        is_icmp;
  logic [31:0] remote_ip;
  logic [31:0] to_ip;
  logic        active;
  logic [15:0] remote_port;
  logic [15:0] to_port;
  logic [15:0] payload_len;
  logic [10:0] byte_no;
  logic        done;
  logic        checksum_ok;

`ifdef UDP_CHECKSUM_EN
  localparam logic EXP_FLIPPED_OK = 1'b0;
`else
  localparam logic EXP_FLIPPED_OK = 1'b1;
`endif

  udp_recv dut (
    .clock       (clock),
    .reset       (reset),
    .rx_enable   (rx_enable),
    .data        (data),
    .is_icmp     (is_icmp),
    .remote_ip   (remote_ip),
    .to_ip       (to_ip),
    .active      (active),
    .remote_port (remote_port),
    .to_port     (to_port),
    .payload_len (payload_len),
    .byte_no     (byte_no),
    .done        (done),
    .checksum_ok (checksum_ok)
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int act_cnt, done_cnt, bn_err, done_cyc, last_cyc;
  logic ck_seen;
  logic [7:0] pkt[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (active) begin
      if (int'(byte_no) != act_cnt + 1) bn_err++;
      act_cnt++;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
      ck_seen  = checksum_ok;
    end
  end

  task automatic add_hdr(input logic [15:0] s, input logic [15:0] d,
                         input logic [15:0] l, input logic [15:0] c);
    pkt.push_back(s[15:8]); pkt.push_back(s[7:0]);
    pkt.push_back(d[15:8]); pkt.push_back(d[7:0]);
    pkt.push_back(l[15:8]); pkt.push_back(l[7:0]);
    pkt.push_back(c[15:8]); pkt.push_back(c[7:0]);
  endtask

  task automatic add_pay(input int n, input logic [7:0] seed);
    for (int i = 0; i < n; i++) pkt.push_back(seed + 8'(i));
  endtask

  // Present the first n queued bytes back to back, then idle long enough to see done
  task automatic send(input logic icmp, input int n);
    act_cnt  = 0;
    done_cnt = 0;
    bn_err   = 0;
    done_cyc = -1;
    ck_seen  = 1'b0;
    for (int i = 0; i < n; i++) begin
      rx_enable = 1'b1;
      is_icmp   = icmp;
      data      = pkt[i];
      last_cyc  = cyc;
      @(posedge clock); #1;
    end
    rx_enable = 1'b0;
    is_icmp   = 1'b0;
    data      = 8'h00;
    repeat (3) begin @(posedge clock); #1; end
    pkt.delete();
  endtask

  initial begin
    reset     = 1'b1;
    rx_enable = 1'b0;
    data      = 8'h00;
    is_icmp   = 1'b0;
    remote_ip = 32'hC0A8_0102;
    to_ip     = 32'hC0A8_0101;
    #12;
    check("rst_active", active, 0);
    check("rst_done", done, 0);
    check("rst_ck", checksum_ok, 0);
    check("rst_rport", remote_port, 0);
    check("rst_tport", to_port, 0);
    check("rst_len", payload_len, 0);
    check("rst_byte_no", byte_no, 0);
    @(posedge clock); #1;
    reset = 1'b0;
    @(posedge clock); #1;

    add_hdr(16'h0400, 16'h0401, 16'h000C, 16'h0000); add_pay(4, 8'hA0);
    send(1'b0, 12);
    check("t1_rport", remote_port, 16'h0400);
    check("t1_tport", to_port, 16'h0401);
    check("t1_len", payload_len, 4);
    check("t1_active_cycles", act_cnt, 4);
    check("t1_byte_no_seq_err", bn_err, 0);
    check("t1_done_pulses", done_cnt, 1);
    check("t1_done_latency", done_cyc, last_cyc + 1);
    check("t1_ck_ok", ck_seen, 1);

    add_hdr(16'h1234, 16'h5678, 16'h0008, 16'h0000);
    send(1'b0, 8);
    check("t2_rport", remote_port, 16'h1234);
    check("t2_tport", to_port, 16'h5678);
    check("t2_len", payload_len, 0);
    check("t2_active_cycles", act_cnt, 0);
    check("t2_done_pulses", done_cnt, 1);
    check("t2_done_latency", done_cyc, last_cyc + 1);

    add_pay(20, 8'h45);
    send(1'b1, 20);
    check("t3_active_cycles", act_cnt, 0);
    check("t3_done_pulses", done_cnt, 0);
    check("t3_rport_hold", remote_port, 16'h1234);
    check("t3_tport_hold", to_port, 16'h5678);
    check("t3_len_hold", payload_len, 0);

    add_hdr(16'h2000, 16'h2001, 16'h0012, 16'h0000); add_pay(10, 8'h10);
    send(1'b0, 10);
    check("t4_len", payload_len, 10);
    check("t4_active_cycles", act_cnt, 2);
    check("t4_done_pulses", done_cnt, 0);

    add_hdr(16'h3000, 16'h3001, 16'h000B, 16'h0000); add_pay(3, 8'h30);
    send(1'b0, 11);
    check("t5_rport", remote_port, 16'h3000);
    check("t5_tport", to_port, 16'h3001);
    check("t5_len", payload_len, 3);
    check("t5_active_cycles", act_cnt, 3);
    check("t5_byte_no_seq_err", bn_err, 0);
    check("t5_done_pulses", done_cnt, 1);

    add_hdr(16'h4000, 16'h4001, 16'h0005, 16'h0000); add_pay(4, 8'h00);
    send(1'b0, 12);
    check("t6_active_cycles", act_cnt, 0);
    check("t6_done_pulses", done_cnt, 0);
    check("t6_len_hold", payload_len, 3);

    add_hdr(16'h5000, 16'h5001, 16'h05C9, 16'h0000); add_pay(4, 8'h00);
    send(1'b0, 12);
    check("t7_active_cycles", act_cnt, 0);
    check("t7_done_pulses", done_cnt, 0);
    check("t7_len_hold", payload_len, 3);

    add_hdr(16'h6000, 16'h6001, 16'h05C8, 16'h0000); add_pay(1472 + 4, 8'h00);
    send(1'b0, 8 + 1472 + 4);
    check("t8_len_max", payload_len, 1472);
    check("t8_active_cycles", act_cnt, 1472);
    check("t8_byte_no_seq_err", bn_err, 0);
    check("t8_done_pulses", done_cnt, 1);

    add_hdr(16'h0400, 16'h0401, 16'h000D, 16'h50AD);
    pkt.push_back(8'h48); pkt.push_back(8'h65); pkt.push_back(8'h6C);
    pkt.push_back(8'h6C); pkt.push_back(8'h6F);
    send(1'b0, 13);
    check("t9_len", payload_len, 5);
    check("t9_done_pulses", done_cnt, 1);
    check("t9_ck_good", ck_seen, 1);

    add_hdr(16'h0400, 16'h0401, 16'h000D, 16'h50AD);
    pkt.push_back(8'h49); pkt.push_back(8'h65); pkt.push_back(8'h6C);
    pkt.push_back(8'h6C); pkt.push_back(8'h6F);
    send(1'b0, 13);
    check("t10_done_pulses", done_cnt, 1);
    check("t10_ck_flipped", ck_seen, EXP_FLIPPED_OK);

    add_hdr(16'h0400, 16'h0401, 16'h000D, 16'h0000);
    pkt.push_back(8'h49); pkt.push_back(8'h65); pkt.push_back(8'h6C);
    pkt.push_back(8'h6C); pkt.push_back(8'h6F);
    send(1'b0, 13);
    check("t11_done_pulses", done_cnt, 1);
    check("t11_ck_zero_field", ck_seen, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/udp_recv.md
Name: udp_recv

Overview:
- Stage directly downstream of the IP receive stage in the protocol2 Ethernet receive path.
- Consumes the IP payload byte stream, gated by the IP stage's active flag, while is_icmp is low.
- Parses the 8-byte UDP header, exposes the source port, destination port and payload length, and flags payload bytes to the port dispatchers.
- Signals end of datagram with a one-cycle done pulse.

Parameters:
- MAX_LEN, 1472: largest accepted UDP payload length in bytes; longer datagrams are dropped.

Ports:
- clock  input  1  system clock; all logic on rising edge
- reset  input  1  asynchronous, active-high reset
- rx_enable  input  1  IP payload byte valid (IP stage active output); low = between packets
- data  input  8  stream byte, valid when rx_enable=1
- is_icmp  input  1  from IP stage; 1 = not UDP, ignore packet
- remote_ip  input  32  sender IP from IP stage (pseudo-header, checksum feature only)
- to_ip  input  32  destination IP from IP stage (pseudo-header, checksum feature only)
- active  output  1  current data byte is UDP payload
- remote_port  output  16  UDP source port
- to_port  output  16  UDP destination port
- payload_len  output  16  UDP length minus 8
- byte_no  output  11  1-based index of the current payload byte
- done  output  1  one-cycle pulse after the last payload byte (or after the header when payload is empty)
- checksum_ok  output  1  checksum verdict, valid while done=1

Behaviour:
- Reset (async): state=ST_IDLE; active=0, done=0, checksum_ok=0; remote_port, to_port, payload_len and byte_no all 0.
- active is combinational: rx_enable & (state==ST_PAYLOAD). done is registered.
- States: ST_IDLE, ST_HEADER, ST_PAYLOAD, ST_DONE. An internal header counter hdr_cnt runs 1..8.
- rx_enable=0 in any state:
  - state goes to ST_IDLE next cycle.
  - If this aborts ST_HEADER or ST_PAYLOAD, done is not pulsed.
  - Port and length outputs hold their last values.
- ST_IDLE with rx_enable=1:
  - is_icmp=1 -> ST_DONE.
  - Otherwise capture the byte as remote_port[15:8], set hdr_cnt=2, go to ST_HEADER.
- ST_HEADER, on each rx_enable byte:
  - hdr 2: remote_port[7:0].
  - hdr 3 and 4: to_port[15:8] and to_port[7:0].
  - hdr 5: length high byte.
  - hdr 6: length low byte. If the full 16-bit length is below 8, or length-8 exceeds MAX_LEN -> ST_DONE (drop, no done). Otherwise payload_len <= length-8.
  - hdr 7 and 8: checksum field. At hdr 8:
    - payload_len==0 -> done=1, ST_DONE.
    - otherwise byte_no=1, ST_PAYLOAD.
- ST_PAYLOAD, on each rx_enable byte:
  - byte_no==payload_len -> done=1 next cycle, ST_DONE.
  - otherwise byte_no increments.
  - Trailing bytes (IP padding, CRC) are ignored in ST_DONE.
- ST_DONE: hold until rx_enable drops.
- Latency: done rises on the cycle after the last payload byte is presented. Ports are stable from the cycle after hdr 4 until the next packet's header.
- Back-to-back packets need at least one rx_enable=0 cycle between them; the IP stage guarantees this.
- rx_enable low on the same cycle the last byte would be taken: no byte was taken, so it aborts with no done.

Optional Feature:
- Macro UDP_CHECKSUM_EN.
- Defined:
  - Running 17-bit end-around-carry ones-complement sum over the pseudo-header: remote_ip, to_ip, 16'h0011, UDP length.
  - Also sums the header including the checksum field, and the payload as big-endian 16-bit words; an odd final byte is padded with 8'h00 in the low half.
  - Pseudo-header words are added during hdr 1-6, one word per cycle.
  - checksum_ok=1 when the folded sum equals 16'hFFFF, or the received checksum field is 16'h0000.
- Undefined: no adder is instantiated; checksum_ok=1 whenever done=1.

Decomposition:
- Shared package eth_rx_pkg holds:
  - state encodings ST_IDLE=4'd1, ST_HEADER=4'd2, ST_PAYLOAD=4'd4, ST_DONE=4'd8 (one-hot, shared with the IP stage);
  - UDP_HDR_LEN=8;
  - IP_PROTO_UDP=8'h11.
- One sub-module, ones_comp_acc: 16-bit ones-complement accumulator with clear, add-word and folded-result ports. Present only under UDP_CHECKSUM_EN.

Test Plan:
- Datagram with src 0x0400, dst 0x0401, length 0x000C, 4 payload bytes -> remote_port=0x0400, to_port=0x0401, payload_len=4; active high for exactly 4 cycles with byte_no 1..4; one done pulse.
- Length 0x0008 -> active never asserts; done pulses the cycle after hdr 8.
- is_icmp=1 for a whole packet -> active=0, done=0, and the ports are unchanged from the previous packet.
- rx_enable dropped after payload byte 2 of 10 -> no done; the next packet with 3 payload bytes parses correctly.
- Length 0x0005, then separately length 8+MAX_LEN+1 -> both dropped: active=0, done=0.
- UDP_CHECKSUM_EN checks, using a known-good captured datagram:
  - odd payload length 5 with correct checksum -> checksum_ok=1;
  - same datagram with one payload bit flipped -> checksum_ok=0;
  - checksum field 0x0000 -> checksum_ok=1.
